// File: rtl/music_pkg.sv
// Shared types and constants for the music note sequencer.
// Default tempo assumes a 50 MHz clock.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_LOAD  = 3'd1,
    REC_HOLD  = 3'd2,
    PLAY_DRAW = 3'd3,
    PLAY_TONE = 3'd4,
    PLAY_GAP  = 3'd5
  } state_t;

  localparam int MAX_NOTES       = 16;
  localparam int DEF_NOTE_CYCLES = 25000000;
  localparam int DEF_GAP_CYCLES  = 2500000;
  localparam int DEF_CNT_W       = 25;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a level input, synchronous active-low reset.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/music_seq_ctrl.sv
// Sequencer for note entry and playback: turns key/button activity into
// datapath strobes, tracks the stored song length and paces playback.
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int NOTE_CYCLES = DEF_NOTE_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_key,
  input  logic       play_btn,
  input  logic       stop_btn,
  input  logic       loop_en,
  output logic       ld_note,
  output logic       ld_play,
  output logic [3:0] note_counter,
  output logic       next_note_en,
  output logic       display_note,
  output logic       sound_en,
  output logic [4:0] note_count,
  output logic       full,
  output logic       playing
);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic             draw_second_q, draw_second_d;
  logic [CNT_W-1:0] tempo_q, tempo_d;
  logic [3:0]       note_ctr_q, note_ctr_d;
  logic [4:0]       note_count_q, note_count_d;
  logic             play_rise, stop_rise;
  logic             in_play;

  edge_det u_play_edge (.clk(clk), .reset(reset), .level(play_btn), .rise(play_rise));
  edge_det u_stop_edge (.clk(clk), .reset(reset), .level(stop_btn), .rise(stop_rise));

  assign in_play = (state_q == PLAY_DRAW) || (state_q == PLAY_TONE) || (state_q == PLAY_GAP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      draw_second_q <= 1'b0;
      tempo_q       <= '0;
      note_ctr_q    <= '0;
      note_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      draw_second_q <= draw_second_d;
      tempo_q       <= tempo_d;
      note_ctr_q    <= note_ctr_d;
      note_count_q  <= note_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    draw_second_d = draw_second_q;
    tempo_d       = tempo_q;
    note_ctr_d    = note_ctr_q;
    note_count_d  = note_count_q;

    // A stop press aborts any playback state and leaves the song intact.
    if (in_play && stop_rise) begin
      state_d       = IDLE;
      draw_second_d = 1'b0;
      tempo_d       = '0;
      note_ctr_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stop_rise) begin
            note_count_d = '0;
          end else if (play_rise && (note_count_q != 5'd0)) begin
            state_d       = PLAY_DRAW;
            note_ctr_d    = '0;
            draw_second_d = 1'b0;
          end else if (note_key && !full) begin
            state_d = REC_LOAD;
          end
        end
        REC_LOAD: begin
          if (note_count_q != 5'(MAX_NOTES)) note_count_d = note_count_q + 5'd1;
          state_d = REC_HOLD;
        end
        REC_HOLD: begin
          if (!note_key) state_d = IDLE;
        end
        PLAY_DRAW: begin
          if (draw_second_q) begin
            state_d       = PLAY_TONE;
            draw_second_d = 1'b0;
            tempo_d       = '0;
          end else begin
            draw_second_d = 1'b1;
          end
        end
        PLAY_TONE: begin
          if (tempo_q == NOTE_LAST) begin
            state_d = PLAY_GAP;
            tempo_d = '0;
          end else begin
            tempo_d = tempo_q + CNT_W'(1);
          end
        end
        PLAY_GAP: begin
          if (tempo_q == GAP_LAST) begin
            tempo_d = '0;
            // note_counter is zero-extended so the last-note test works at 16 notes.
            if (({1'b0, note_ctr_q} + 5'd1) < note_count_q) begin
              note_ctr_d = note_ctr_q + 4'd1;
              state_d    = PLAY_DRAW;
            end else if (loop_en) begin
              note_ctr_d = '0;
              state_d    = PLAY_DRAW;
            end else begin
              note_ctr_d = '0;
              state_d    = IDLE;
            end
          end else begin
            tempo_d = tempo_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ld_note      = (state_q == REC_LOAD);
  assign display_note = (state_q == REC_HOLD);
  assign ld_play      = (state_q == PLAY_DRAW);
  assign next_note_en = (state_q == PLAY_DRAW) && !draw_second_q;
  assign sound_en     = (state_q == PLAY_TONE);
  assign playing      = in_play;
  assign note_counter = note_ctr_q;
  assign note_count   = note_count_q;
  assign full         = (note_count_q == 5'(MAX_NOTES));

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Top-level sequencer for the note-entry/playback datapath.
- Converts user key and button activity into the datapath's `ld_note` and `ld_play` strobes, the `note_counter` address and the `next_note_en` strobe.
- Tracks how many notes are stored (0..16) and paces playback with a tempo counter.
- Drives `sound_en` to gate the tone generator fed by `freq_out`.

Parameters:
- NOTE_CYCLES, 25000000, clk cycles each note sounds during playback (0.5 s at 50 MHz); must be >= 2.
- GAP_CYCLES, 2500000, silent clk cycles between consecutive notes; must be >= 1.
- CNT_W, 25, width of the tempo counter; must satisfy 2^CNT_W > max(NOTE_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- note_key  in  1  level; high while any note key is held
- play_btn  in  1  level; start playback, edge-detected internally
- stop_btn  in  1  level; abort playback / clear song, edge-detected internally
- loop_en  in  1  level; restart from note 0 after the last note
- ld_note  out  1  one-cycle write strobe to the datapath
- ld_play  out  1  playback draw strobe to the datapath, held exactly 2 cycles per note
- note_counter  out  4  index of the note being played
- next_note_en  out  1  one-cycle pulse when a new note starts (vga_data advance)
- display_note  out  1  high in REC_HOLD (note being entered shown)
- sound_en  out  1  tone enable
- note_count  out  5  number of stored notes, 0..16
- full  out  1  note_count == 16
- playing  out  1  high in PLAY_DRAW/PLAY_TONE/PLAY_GAP

Behaviour:
- Reset (sync, active-low; all registers cleared in the same cycle):
  - state = IDLE, note_count = 0, note_counter = 0, tempo counter = 0, button edge registers = 0.
  - All outputs 0.
- Edge detect: play_rise/stop_rise = current level & ~previous registered level. Each press is one event regardless of hold time.
- States and transitions:
  - IDLE:
    - stop_rise -> note_count <= 0 (clear song).
    - else play_rise & note_count != 0 -> PLAY_DRAW, note_counter <= 0.
    - else note_key & ~full -> REC_LOAD.
  - REC_LOAD (1 cycle): ld_note = 1, note_count <= note_count + 1 -> REC_HOLD.
  - REC_HOLD: display_note = 1, ld_note = 0. Wait for note_key = 0 -> IDLE.
    - ld_note is never high two cycles in a row, so the datapath write-enable handshake sees a low cycle between writes.
  - PLAY_DRAW (exactly 2 cycles, internal flag):
    - ld_play = 1 in both cycles; next_note_en = 1 in the first cycle only.
    - Then -> PLAY_TONE with tempo counter = 0.
  - PLAY_TONE: sound_en = 1. When the counter reaches NOTE_CYCLES-1 -> PLAY_GAP with counter reset.
  - PLAY_GAP: sound_en = 0. When the counter reaches GAP_CYCLES-1:
    - note_counter + 1 < note_count -> note_counter++, go to PLAY_DRAW.
    - else loop_en -> note_counter <= 0, go to PLAY_DRAW.
    - else -> IDLE, note_counter <= 0.
- Stop during playback: stop_rise in any PLAY_* state -> IDLE next cycle. sound_en and ld_play fall the same edge; note_count is retained. stop_rise in the same cycle as play_rise: stop wins.
- Recording and playback are mutually exclusive. note_key and play_btn are ignored while playing; play_rise is ignored in REC_*.
- full: note_key in IDLE with note_count == 16 is ignored; no ld_note. note_count saturates and never wraps.
- note_counter is always < note_count while playing. Width rule: 4-bit note_counter compared against 5-bit note_count with zero-extension.
- Reset mid-playback or mid-record: immediate return to the reset values above.

Decomposition:
- Shared package `music_pkg`:
  - state enum (IDLE, REC_LOAD, REC_HOLD, PLAY_DRAW, PLAY_TONE, PLAY_GAP);
  - MAX_NOTES = 16;
  - default tempo constants.
- Sub-module `edge_det` (1-bit rising-edge detector with sync active-low reset), instantiated twice (play, stop).

Test Plan:
- Use NOTE_CYCLES=4 and GAP_CYCLES=2 for all scenarios.
- Record: 3 key presses (held 5 cycles, released 3) -> ld_note single-cycle pulse ×3, note_count = 3, display_note high during each hold.
- Full: 17 presses -> exactly 16 ld_note pulses, full = 1, note_count = 16; 17th press produces no pulse.
- Playback, 3 notes, loop_en = 0:
  - per note: ld_play high 2 cycles, next_note_en 1 cycle, sound_en high 4 cycles, low 2 cycles;
  - note_counter sequence 0, 1, 2, then IDLE, playing = 0.
- Loop: same song with loop_en = 1 -> note_counter 0, 1, 2, 0, 1 continues; stop press then drops sound_en on the next edge and returns to IDLE with note_count = 3.
- Play with empty song -> stays IDLE, no ld_play; simultaneous play+stop press in IDLE -> note_count cleared to 0, no playback.
- Reset asserted during PLAY_TONE -> next edge all outputs 0, note_count = 0, state IDLE.
